// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a requester
// and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       busy;
  logic       done;
  logic       err;
  logic       rx_inhibit;

  modport master (
    output tx_data,
    output tx_req,
    input  busy,
    input  done,
    input  err,
    input  rx_inhibit
  );

  modport slave (
    input  tx_data,
    input  tx_req,
    output busy,
    output done,
    output err,
    output rx_inhibit
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Drives the shared open-drain lines through oe outputs.
module ps2_host_tx #(
  parameter int CLK_FREQ         = 28_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int FRAME_TIMEOUT_US = 2000,
  parameter int FILTER_LEN       = 8
) (
  input  logic         clk28,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);
  localparam int CYC_US  = CLK_FREQ / 1_000_000;
  localparam int INH_CNT = CYC_US * INHIBIT_US;
  localparam int STA_CNT = CYC_US * START_TIMEOUT_US;
  localparam int FRM_CNT = CYC_US * FRAME_TIMEOUT_US;
  localparam int MAX0    =
    (STA_CNT > FRM_CNT) ? STA_CNT : FRM_CNT;
  localparam int MAX_CNT =
    (MAX0 > INH_CNT + 1) ? MAX0 : INH_CNT + 1;
  localparam int TMR_W   = $clog2(MAX_CNT + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_DATA,
    S_ACK,
    S_RECOVER,
    S_END,
    S_FAIL
  } state_t;

  logic [1:0]       r_csync;
  logic [1:0]       r_dsync;
  logic [FLT_W-1:0] r_ccnt;
  logic [FLT_W-1:0] r_dcnt;
  logic             r_fclk;
  logic             r_fdat;
  logic             r_fclk_q;
  logic             w_fall;

  state_t           r_state;
  state_t           w_state;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmr;
  logic [9:0]       r_shift;
  logic [9:0]       w_shift;
  logic [3:0]       r_bitcnt;
  logic [3:0]       w_bitcnt;
  logic             r_nack;
  logic             w_nack;
  logic             r_clk_oe;
  logic             w_clk_oe;
  logic             r_dat_oe;
  logic             w_dat_oe;
  logic             r_busy;
  logic             w_busy;
  logic             r_done;
  logic             w_done;
  logic             r_err;
  logic             w_err;

  logic w_inh_last;
  logic w_inh_end;
  logic w_sta_to;
  logic w_frm_to;

  // synchronize both pins and accept a level only after it is stable
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_csync  <= 2'b11;
      r_dsync  <= 2'b11;
      r_ccnt   <= '0;
      r_dcnt   <= '0;
      r_fclk   <= 1'b1;
      r_fdat   <= 1'b1;
      r_fclk_q <= 1'b1;
    end else begin
      r_csync  <= {r_csync[0], ps2_clk_in};
      r_dsync  <= {r_dsync[0], ps2_dat_in};
      r_fclk_q <= r_fclk;
      if (r_csync[1] == r_fclk) begin
        r_ccnt <= '0;
      end else if (r_ccnt == FLT_W'(FILTER_LEN - 1)) begin
        r_fclk <= r_csync[1];
        r_ccnt <= '0;
      end else begin
        r_ccnt <= r_ccnt + FLT_W'(1);
      end
      if (r_dsync[1] == r_fdat) begin
        r_dcnt <= '0;
      end else if (r_dcnt == FLT_W'(FILTER_LEN - 1)) begin
        r_fdat <= r_dsync[1];
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + FLT_W'(1);
      end
    end
  end

  assign w_fall = r_fclk_q & ~r_fclk;

  assign w_inh_last = (r_tmr == TMR_W'(INH_CNT - 1));
  assign w_inh_end  = (r_tmr == TMR_W'(INH_CNT));
  assign w_sta_to   = (r_tmr == TMR_W'(STA_CNT - 1));
  assign w_frm_to   = (r_tmr == TMR_W'(FRM_CNT - 1));

  // state, frame datapath and registered outputs
  always_ff @(posedge clk28) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_shift  <= '1;
      r_bitcnt <= '0;
      r_nack   <= 1'b0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_tmr    <= w_tmr;
      r_shift  <= w_shift;
      r_bitcnt <= w_bitcnt;
      r_nack   <= w_nack;
      r_clk_oe <= w_clk_oe;
      r_dat_oe <= w_dat_oe;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_err    <= w_err;
    end
  end

  // next-state decision; timeouts win over a late clock edge
  always_comb begin
    w_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.tx_req) w_state = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (w_inh_end) w_state = S_START;
      end
      S_START: begin
        if (w_fall)        w_state = S_DATA;
        else if (w_sta_to) w_state = S_FAIL;
      end
      S_DATA: begin
        if (w_frm_to) w_state = S_FAIL;
        else if (w_fall && r_bitcnt == 4'd8)
          w_state = S_ACK;
      end
      S_ACK: begin
        if (w_frm_to)    w_state = S_FAIL;
        else if (w_fall) w_state = S_RECOVER;
      end
      S_RECOVER: begin
        if (w_frm_to) w_state = S_FAIL;
        else if (r_fclk && r_fdat)
          w_state = S_END;
      end
      S_END:   w_state = S_IDLE;
      S_FAIL:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // next values of the datapath and of the line/status outputs
  always_comb begin
    w_tmr    = (r_tmr == '1) ? r_tmr : r_tmr + TMR_W'(1);
    w_shift  = r_shift;
    w_bitcnt = r_bitcnt;
    w_nack   = r_nack;
    w_clk_oe = r_clk_oe;
    w_dat_oe = r_dat_oe;
    unique case (r_state)
      S_IDLE: begin
        w_tmr = '0;
        if (bus.tx_req) begin
          w_shift  = {1'b1, ~^bus.tx_data, bus.tx_data};
          w_bitcnt = '0;
          w_nack   = 1'b0;
          w_clk_oe = 1'b1;
          w_dat_oe = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (w_inh_last) w_dat_oe = 1'b1;
        if (w_inh_end) begin
          w_clk_oe = 1'b0;
          w_tmr    = '0;
        end
      end
      S_START: begin
        if (w_fall) begin
          w_dat_oe = ~r_shift[0];
          w_shift  = {1'b1, r_shift[9:1]};
          w_bitcnt = '0;
          w_tmr    = '0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_dat_oe = ~r_shift[0];
          w_shift  = {1'b1, r_shift[9:1]};
          w_bitcnt = r_bitcnt + 4'd1;
        end
      end
      S_ACK: begin
        if (w_fall) w_nack = r_fdat;
      end
      default: begin
      end
    endcase
    if (w_state == S_FAIL) begin
      w_clk_oe = 1'b0;
      w_dat_oe = 1'b0;
    end
    w_busy = (w_state != S_IDLE);
    w_done = (w_state == S_END) || (w_state == S_FAIL);
    w_err  = (w_state == S_FAIL) ||
             ((w_state == S_END) && r_nack);
  end

  assign ps2_clk_oe     = r_clk_oe;
  assign ps2_dat_oe     = r_dat_oe;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rx_inhibit = r_busy;
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; it sends command bytes to the keyboard, such as the LED (0xED) and reset (0xFF) commands.
- It is the opposite direction to the existing ps2 receiver and shares the same two open-drain lines.
- While a frame is in flight it asserts rx_inhibit so the receiver ignores the traffic.
- It runs on clk28 alongside the receiver.

Parameters:
- CLK_FREQ, 28_000_000: clk28 frequency in Hz. All time counts derive from it as CLK_FREQ/1_000_000 * us.
- INHIBIT_US, 120: time PS/2 clock is held low before the start bit.
- START_TIMEOUT_US, 15000: maximum wait from clock release to the device's first falling clock edge.
- FRAME_TIMEOUT_US, 2000: maximum time from the first falling edge to ack sampled.
- FILTER_LEN, 8: number of consecutive identical synchronized samples needed to accept a line level change.

Ports:
- clk28  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- tx_data  in  8  byte to send; sampled when tx_req && !busy.
- tx_req  in  1  one-cycle request strobe.
- busy  out  1  high from the accepted request until done.
- done  out  1  one-cycle pulse at the end of every accepted frame, whether it succeeded or failed.
- err  out  1  one-cycle pulse coincident with done when the frame failed (timeout or no ack).
- rx_inhibit  out  1  equals busy; the ps2 receiver discards bits while it is high.
- ps2_clk_in  in  1  raw PS/2 clock pin level (asynchronous).
- ps2_dat_in  in  1  raw PS/2 data pin level (asynchronous).
- ps2_clk_oe  out  1  1 = drive the clock pin low; 0 = release it.
- ps2_dat_oe  out  1  1 = drive the data pin low; 0 = release it.

Behaviour:
Reset and idle
- In reset and idle: busy=0, done=0, err=0, ps2_clk_oe=0, ps2_dat_oe=0, state=IDLE, filters preset to 1.
- Reset asserted mid-frame: both oe outputs are 0 on the first cycle after the rst edge. No done or err pulse is produced.

Input conditioning
- Each pin passes through a 2-FF synchronizer, then a FILTER_LEN stability filter.
- fclk_fall is a one-cycle pulse when the filtered clock goes 1 to 0.

Frame contents
- Frame is: start bit 0, 8 data bits LSB first, odd parity, stop bit 1, then device ack.
- Parity bit = ~^tx_data.
- The shift register and parity are latched at accept; later changes to tx_data have no effect.

State machine
- IDLE: when tx_req is asserted, latch the frame, set busy=1, clear the timer, go to INHIBIT.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_US counts. On the last count set dat_oe=1 (start bit). The next cycle sets clk_oe=0 and goes to START.
- START: dat_oe stays 1.
  - On fclk_fall: bitcnt=0, present bit0 (dat_oe=~bit), restart the timer, go to DATA.
  - If the timer reaches START_TIMEOUT_US: go to FAIL.
- DATA: each fclk_fall presents the next bit.
  - Bits 1..7 are data bits.
  - The 9th fall in the frame presents parity.
  - The 10th fall releases data (dat_oe=0, stop bit); go to ACK.
- ACK: on the 11th fall sample the filtered data line; 0 = ack OK, 1 = no ack. Go to RECOVER.
- RECOVER: wait until the filtered clock and data are both 1, then go to END.
  - On a good ack: done=1, err=0.
  - On no ack: done=1, err=1.
- Frame timeout: from START exit onward, the timer reaching FRAME_TIMEOUT_US before END sends the machine to FAIL.
- FAIL: both oe outputs 0; done=1, err=1 for one cycle; go to IDLE.
- END: busy=0 on the cycle after done; return to IDLE.

Handshake
- tx_req while busy=1 is ignored and does not queue.
- The timer is saturating and wide enough for START_TIMEOUT_US: 19 bits at the default parameters.
- The oe outputs are registered and never both 1 except during the single INHIBIT-to-START transition cycle.
- A new request on the same cycle as done is ignored; it is accepted one cycle later at the earliest.

Test Plan:
- Send 0xED, LED command:
  - Device model clocks at 12.5 kHz and acks.
  - Required: clk held low ≥3360 cycles; start=0; data bits sampled on rising clock edges are 1,0,1,1,0,1,1,1; parity=1; stop=1.
  - Required: done=1, err=0; busy falls one cycle later.
- Send 0x01, then 0x00:
  - Required: parity is 0, then 1.
  - Required: rx_inhibit=1 for the whole of each frame.
- Device never clocks:
  - Required: exactly 420000 cycles after clock release, done=1 and err=1; both oe outputs 0; busy=0 next cycle.
- Device completes 11 clocks but leaves data high at the 11th fall:
  - Required: done=1, err=1 after the lines idle high.
- Control-path checks:
  - tx_req pulsed mid-frame with 0x55: frame content unchanged and no second frame follows.
  - rst asserted during DATA: both oe outputs 0 the next cycle; no done pulse.
  - 3-cycle glitch on ps2_clk_in: no extra bit shifted.
